// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: one shared shift-add / restoring-divide
// datapath, one result bit per cycle, valid/ready handshakes on both sides.
module alu_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] c_o,
  output logic            busy_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  count;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   acc_hi, acc_lo, opd;
  logic              neg_q, neg_rem_q;

  logic              accept, fast;
  logic              a_signed, b_signed, sign_a, sign_b, b_zero, ovf;
  logic [XLEN-1:0]   mag_a, mag_b, fast_res;

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]   iter_hi, iter_lo, quo, rem, final_res;
  logic [2*XLEN-1:0] prod;

  assign in_ready_o  = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign out_valid_o = (state == DONE) && !flush_i;
  assign accept      = in_valid_i && in_ready_o && !flush_i;

  // Operand decode and the divide fast path, evaluated only at acceptance.
  always_comb begin
    a_signed = (op_i == 3'b000) || (op_i == 3'b001) || (op_i == 3'b010) ||
               (op_i == 3'b100) || (op_i == 3'b110);
    b_signed = (op_i == 3'b000) || (op_i == 3'b001) ||
               (op_i == 3'b100) || (op_i == 3'b110);
    sign_a   = a_signed && a_i[XLEN-1];
    sign_b   = b_signed && b_i[XLEN-1];
    mag_a    = sign_a ? -a_i : a_i;
    mag_b    = sign_b ? -b_i : b_i;
    b_zero   = (b_i == '0);
    ovf      = !op_i[0] && (a_i == MIN_NEG) && (b_i == '1);
    fast     = op_i[2] && (b_zero || ovf);
    if (b_zero) fast_res = op_i[1] ? a_i : '1;
    else        fast_res = op_i[1] ? '0 : a_i;
  end

  // acc_hi/acc_lo hold {product high, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opd};
    if (op_q[2]) begin
      iter_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      iter_lo = {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      iter_hi = mul_sum[XLEN:1];
      iter_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
    prod = neg_q ? -{iter_hi, iter_lo} : {iter_hi, iter_lo};
    quo  = neg_q ? -iter_lo : iter_lo;
    rem  = neg_rem_q ? -iter_hi : iter_hi;
    if (op_q[2])              final_res = op_q[1] ? rem : quo;
    else if (op_q[1:0] == '0) final_res = prod[XLEN-1:0];
    else                      final_res = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = fast ? DONE : CALC;
      CALC:    if (count == '0) state_next = DONE;
      DONE:    if (out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      op_q      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opd       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      c_o       <= '0;
    end else if (accept) begin
      count     <= CNT_W'(XLEN-1);
      op_q      <= op_i;
      acc_hi    <= '0;
      acc_lo    <= op_i[2] ? mag_a : mag_b;
      opd       <= op_i[2] ? mag_b : mag_a;
      neg_q     <= sign_a ^ sign_b;
      neg_rem_q <= sign_a;
      if (fast) c_o <= fast_res;
    end else if (state == CALC && !flush_i) begin
      acc_hi <= iter_hi;
      acc_lo <= iter_lo;
      count  <= count - CNT_W'(1);
      if (count == '0) c_o <= final_res;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: drives an XLEN=32 and an XLEN=8 instance
// with directed RV32M corner cases and random vectors.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready, sel8;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        in_ready32, out_valid32, busy32;
  logic        in_ready8, out_valid8, busy8;
  logic [31:0] c32;
  logic [7:0]  c8;
  logic        in_ready_obs, out_valid_obs, busy_obs;
  logic [31:0] c_obs;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a32, b32, e32;
    logic [7:0]  a8, b8, e8;
    bit          fast;
  } vec_t;

  vec_t dir [13] = '{
    '{3'b000, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 8'h07, 8'hFD, 8'hEB, 1'b0},
    '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 8'h80, 8'h80, 8'h40, 1'b0},
    '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 8'hFF, 8'hFF, 8'hFE, 1'b0},
    '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 1'b0},
    '{3'b100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 8'hF9, 8'h02, 8'hFD, 1'b0},
    '{3'b110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 8'hF9, 8'h02, 8'hFF, 1'b0},
    '{3'b101, 32'h7,        32'h2,        32'h3,        8'h07, 8'h02, 8'h03, 1'b0},
    '{3'b111, 32'h7,        32'h2,        32'h1,        8'h07, 8'h02, 8'h01, 1'b0},
    '{3'b110, 32'h7,        32'hFFFFFFFE, 32'h1,        8'h07, 8'hFE, 8'h01, 1'b0},
    '{3'b100, 32'h5,        32'h0,        32'hFFFFFFFF, 8'h05, 8'h00, 8'hFF, 1'b1},
    '{3'b111, 32'h5,        32'h0,        32'h5,        8'h05, 8'h00, 8'h05, 1'b1},
    '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'h80, 8'hFF, 8'h80, 1'b1},
    '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        8'h80, 8'hFF, 8'h00, 1'b1}
  };

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid && !sel8), .in_ready_o(in_ready32),
    .op_i(op), .a_i(a), .b_i(b),
    .out_valid_o(out_valid32), .out_ready_i(out_ready),
    .c_o(c32), .busy_o(busy32)
  );

  alu_muldiv #(.XLEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid && sel8), .in_ready_o(in_ready8),
    .op_i(op), .a_i(a[7:0]), .b_i(b[7:0]),
    .out_valid_o(out_valid8), .out_ready_i(out_ready),
    .c_o(c8), .busy_o(busy8)
  );

  assign in_ready_obs  = sel8 ? in_ready8  : in_ready32;
  assign out_valid_obs = sel8 ? out_valid8 : out_valid32;
  assign busy_obs      = sel8 ? busy8      : busy32;
  assign c_obs         = sel8 ? {24'b0, c8} : c32;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Behavioural RV32M reference, generalised to width w.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y, input int w);
    longint mask, ux, uy, sx, sy, q, r;
    logic signed [127:0] px, py, p;
    mask = (longint'(1) << w) - 1;
    ux = longint'(x) & mask;
    uy = longint'(y) & mask;
    sx = ux - ((((ux >> (w-1)) & 1) != 0) ? (longint'(1) << w) : 0);
    sy = uy - ((((uy >> (w-1)) & 1) != 0) ? (longint'(1) << w) : 0);
    if (!o[2]) begin
      px = (o == 3'b011) ? 128'(ux) : 128'(sx);
      py = (o[1]) ? 128'(uy) : 128'(sy);
      p = px * py;
      if (o == 3'b000) return 32'(p & 128'(mask));
      return 32'((p >> w) & 128'(mask));
    end
    if (uy == 0) return o[1] ? 32'(ux) : 32'(mask);
    if (!o[0]) begin
      if (sx == -(longint'(1) << (w-1)) && sy == -1) return o[1] ? 32'd0 : 32'(ux);
      q = sx / sy;
      r = sx % sy;
    end else begin
      q = ux / uy;
      r = ux % uy;
    end
    return 32'((o[1] ? r : q) & mask);
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp,
                        input int exp_lat, input int hold);
    int t;
    int lat;
    logic [31:0] held;
    sb_t e;
    t = 0;
    while (!in_ready_obs && t < 50) begin @(negedge clk); t++; end
    check({tag, "/ready"}, in_ready_obs, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    sb_q.push_back('{tag, exp});
    @(negedge clk);
    in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid_obs && lat < 200) begin @(negedge clk); lat++; end
    check({tag, "/valid"}, out_valid_obs, 1);
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/in_ready_in_done"}, in_ready_obs, 0);
    check({tag, "/sb_depth"}, sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.tag, "/c_o"}, c_obs, e.exp);
    end
    held = c_obs;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
      @(negedge clk);
      check({tag, "/hold_c_o"}, c_obs, held);
      check({tag, "/hold_valid"}, out_valid_obs, 1);
      check({tag, "/hold_in_ready"}, in_ready_obs, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/idle_after"}, in_ready_obs, 1);
    check({tag, "/c_o_retained"}, c_obs, held);
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFFFFFF : 32'h000000FF;
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return mask;
      3:       return (mask >> 1) + 32'h1;
      4:       return mask >> 1;
      default: return $urandom & mask;
    endcase
  endfunction

  task automatic abort_check(input string tag);
    int nval;
    check({tag, "/in_ready"}, in_ready_obs, 1);
    check({tag, "/busy"}, busy_obs, 0);
    check({tag, "/out_valid"}, out_valid_obs, 0);
    nval = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_obs) nval++;
    end
    check({tag, "/no_result"}, nval, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    logic [2:0]  ro;
    logic [31:0] ra, rb, mask;
    int elat;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel8 = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel8 = (s == 1);
      #1;
      check("reset/out_valid", out_valid_obs, 0);
      check("reset/c_o", c_obs, 0);
      check("reset/busy", busy_obs, 0);
      check("reset/in_ready", in_ready_obs, 1);
    end
    sel8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      sel8 = (s == 1);
      w = sel8 ? 8 : 32;
      mask = sel8 ? 32'hFF : 32'hFFFFFFFF;
      foreach (dir[i]) begin
        if (sel8)
          run_op($sformatf("dir8_%0d", i), dir[i].o, {24'b0, dir[i].a8}, {24'b0, dir[i].b8},
                 {24'b0, dir[i].e8}, dir[i].fast ? 1 : w + 1, 0);
        else
          run_op($sformatf("dir32_%0d", i), dir[i].o, dir[i].a32, dir[i].b32,
                 dir[i].e32, dir[i].fast ? 1 : w + 1, 0);
      end
      for (int i = 0; i < 24; i++) begin
        ro = 3'($urandom);
        ra = pick(w);
        rb = pick(w);
        elat = (ro[2] && ((rb & mask) == 0 ||
                (!ro[0] && (ra & mask) == ((mask >> 1) + 1) && (rb & mask) == mask))) ? 1 : w + 1;
        run_op($sformatf("rnd%0d_%0d", w, i), ro, ra, rb, ref_model(ro, ra, rb, w), elat, 0);
      end
    end

    sel8 = 1'b0;
    run_op("hold_divu", 3'b101, 32'd100, 32'd7, 32'd14, 33, 10);

    op = 3'b101; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    abort_check("flush_calc");

    op = 3'b000; a = 32'd9; b = 32'd9; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    abort_check("flush_idle");

    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33, 0);

    op = 3'b000; a = 32'd5; b = 32'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_mid/c_o", c_obs, 0);
    abort_check("reset_mid");

    run_op("mul_after_reset", 3'b000, 32'd3, 32'd4, 32'd12, 33, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
